// File: rtl/pipe_pkg.sv
// Shared types and per-stage widths for the pipelined RISC-V core's stage registers.
// Stage wrappers pack their named fields LSB first into the data payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // IF/ID: ctrl = predicted-taken hint; data = {instr, pc}
    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;

    // ID/EX: ctrl = {alu_op[1:0], alu_src, branch, mem_write, mem_read, mem_to_reg, reg_write}
    //        data = {pc, rs1_val, rs2_val, imm, rs2, rs1, rd}
    localparam int ID_EX_CTRL_W  = 8;
    localparam int ID_EX_DATA_W  = 143;

    // EX/MEM: ctrl = {mem_write, mem_read, mem_to_reg, reg_write}; data = {alu, store_data, rd}
    localparam int EX_MEM_CTRL_W = 4;
    localparam int EX_MEM_DATA_W = 69;

    // MEM/WB: ctrl = {mem_to_reg, reg_write}; data = {alu, read_data, rd}
    localparam int MEM_WB_CTRL_W = 2;
    localparam int MEM_WB_DATA_W = 69;

    localparam int MEM_WB_RD_LSB    = 0;
    localparam int MEM_WB_RDATA_LSB = 5;
    localparam int MEM_WB_ALU_LSB   = 37;

    function automatic logic [1:0] occ_of(pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

    function automatic logic [MEM_WB_DATA_W-1:0] pack_mem_wb(
        input logic [31:0] alu,
        input logic [31:0] read_data,
        input logic [4:0]  rd
    );
        return {alu, read_data, rd};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// An entry moves on a clock edge where valid and ready are both 1; valid must hold until then.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69
);
    import pipe_pkg::*;

    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] data_i;
    logic              valid_o;
    logic              ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        occ_o;
    pipe_state_t       state;

    modport slave (
        input  flush_i, valid_i, ctrl_i, data_i, ready_i,
        output ready_o, valid_o, ctrl_o, data_o, occ_o, state
    );

    modport master (
        output flush_i, valid_i, ctrl_i, data_i, ready_i,
        input  ready_o, valid_o, ctrl_o, data_o, occ_o, state
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline register with flush, bubble-gated control and an optional
// 2-entry skid buffer that makes ready_o a register output.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 2,
    parameter int DATA_W  = 69,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_stage_reg_if.slave   bus
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic              accept;
    logic              emit;
    logic [CTRL_W-1:0] head_ctrl_q;
    logic [DATA_W-1:0] head_data_q;

    assign accept = bus.valid_i && bus.ready_o;
    assign emit   = bus.valid_o && bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A bubble never carries control bits, so a flushed stage cannot trigger a write.
    assign bus.valid_o = (state_q != EMPTY);
    assign bus.ctrl_o  = head_ctrl_q & {CTRL_W{bus.valid_o}};
    assign bus.data_o  = head_data_q;
    assign bus.occ_o   = occ_of(state_q);
    assign bus.state   = state_q;

    generate
        if (SKID_EN) begin : g_skid
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              ready_q;

            always_comb begin
                state_d = state_q;
                if (bus.flush_i) begin
                    state_d = EMPTY;
                end else begin
                    case (state_q)
                        EMPTY:   if (accept) state_d = ONE;
                        ONE: begin
                            if (accept && !emit)      state_d = FULL;
                            else if (!accept && emit) state_d = EMPTY;
                        end
                        FULL:    if (emit) state_d = ONE;
                        default: state_d = EMPTY;
                    endcase
                end
            end

            // ready is computed from the next state so it is a clean flop output.
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_d != FULL);
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else if (!bus.flush_i) begin
                    case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                head_ctrl_q <= bus.ctrl_i;
                                head_data_q <= bus.data_i;
                            end
                        end
                        ONE: begin
                            if (accept && emit) begin
                                head_ctrl_q <= bus.ctrl_i;
                                head_data_q <= bus.data_i;
                            end else if (accept) begin
                                skid_ctrl_q <= bus.ctrl_i;
                                skid_data_q <= bus.data_i;
                            end
                        end
                        FULL: begin
                            if (emit) begin
                                head_ctrl_q <= skid_ctrl_q;
                                head_data_q <= skid_data_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign bus.ready_o = ready_q;
        end else begin : g_single
            always_comb begin
                state_d = state_q;
                if (bus.flush_i) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    state_d = ONE;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    head_ctrl_q <= '0;
                    head_data_q <= '0;
                end else if (!bus.flush_i && accept) begin
                    head_ctrl_q <= bus.ctrl_i;
                    head_data_q <= bus.data_i;
                end
            end

            assign bus.ready_o = !bus.valid_o || bus.ready_i;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid-buffered and one single-entry instance, each with
// a FIFO scoreboard, plus a vector table for the skid instance's multi-cycle behaviour.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = 2;
    localparam int DW = 69;
    localparam int W  = CW + DW;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int           b_pushed;
    int           b_popped;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_a ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_b ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a.slave)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic v, input logic r, input logic f,
                           input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus_a.valid_i = v;
        bus_a.ready_i = r;
        bus_a.flush_i = f;
        bus_a.ctrl_i  = c;
        bus_a.data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input logic r, input logic f,
                           input logic [CW-1:0] c, input logic [DW-1:0] d);
        bus_b.valid_i = v;
        bus_b.ready_i = r;
        bus_b.flush_i = f;
        bus_b.ctrl_i  = c;
        bus_b.data_i  = d;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs are stable at the falling edge, so the upcoming edge's
    // accept/emit/flush are known here; invariants are checked before the queue moves.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete();
        end else begin
            check("a_occ", bus_a.occ_o, exp_a.size());
            check("a_valid", bus_a.valid_o, exp_a.size() != 0);
            check("a_ready", bus_a.ready_o, exp_a.size() != 2);
            if (!bus_a.valid_o) check("a_bubble_ctrl", bus_a.ctrl_o, 0);
            if (bus_a.valid_o && bus_a.ready_i) begin
                check("a_emit_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) check("a_order", {bus_a.ctrl_o, bus_a.data_o}, exp_a.pop_front());
            end
            if (bus_a.flush_i) exp_a.delete();
            else if (bus_a.valid_i && bus_a.ready_o) exp_a.push_back({bus_a.ctrl_i, bus_a.data_i});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_b.delete();
        end else begin
            check("b_occ", bus_b.occ_o, exp_b.size());
            check("b_valid", bus_b.valid_o, exp_b.size() != 0);
            check("b_ready", bus_b.ready_o, !bus_b.valid_o || bus_b.ready_i);
            if (!bus_b.valid_o) check("b_bubble_ctrl", bus_b.ctrl_o, 0);
            if (bus_b.valid_o && bus_b.ready_i) begin
                check("b_emit_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    check("b_order", {bus_b.ctrl_o, bus_b.data_o}, exp_b.pop_front());
                    b_popped++;
                end
            end
            if (bus_b.flush_i) exp_b.delete();
            else if (bus_b.valid_i && bus_b.ready_o) begin
                exp_b.push_back({bus_b.ctrl_i, bus_b.data_i});
                b_pushed++;
            end
        end
    end

    typedef struct {
        logic          valid;
        logic          ready;
        logic          flush;
        logic [CW-1:0] ctrl;
        logic [7:0]    data;
        logic          exp_valid;
        logic          exp_ready;
        logic [1:0]    exp_occ;
        logic [CW-1:0] exp_ctrl;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // {valid, ready_i, flush, ctrl, data} -> expected after the edge {valid_o, ready_o, occ_o, ctrl_o}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h0A, 1'b1, 1'b1, 2'd1, 2'b01};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b10, 8'h0B, 1'b1, 1'b0, 2'd2, 2'b01};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h0C, 1'b1, 1'b0, 2'd2, 2'b01};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h0C, 1'b1, 1'b1, 2'd1, 2'b10};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b11, 8'h0C, 1'b1, 1'b1, 2'd1, 2'b11};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 2'd0, 2'b00};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'b11, 8'h55, 1'b0, 1'b1, 2'd0, 2'b00};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h21, 1'b1, 1'b1, 2'd1, 2'b01};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'b10, 8'h22, 1'b0, 1'b1, 2'd0, 2'b00};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b11, 8'h31, 1'b1, 1'b1, 2'd1, 2'b11};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'b01, 8'h32, 1'b1, 1'b0, 2'd2, 2'b11};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 2'd0, 2'b00};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 2'd0, 2'b00};

        checks   = 0;
        errors   = 0;
        b_pushed = 0;
        b_popped = 0;

        // Reset held with upstream valid asserted on both instances
        rst_n = 1'b0;
        bus_a.valid_i = 1'b1; bus_a.ready_i = 1'b0; bus_a.flush_i = 1'b0;
        bus_a.ctrl_i  = 2'b11; bus_a.data_i = 69'h77;
        bus_b.valid_i = 1'b1; bus_b.ready_i = 1'b0; bus_b.flush_i = 1'b0;
        bus_b.ctrl_i  = 2'b11; bus_b.data_i = 69'h77;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_valid", bus_a.valid_o, 0);
        check("rst_a_ctrl",  bus_a.ctrl_o, 0);
        check("rst_a_occ",   bus_a.occ_o, 0);
        check("rst_a_ready", bus_a.ready_o, 1);
        check("rst_a_data",  bus_a.data_o, 0);
        check("rst_b_valid", bus_b.valid_o, 0);
        check("rst_b_ready", bus_b.ready_o, 1);
        rst_n = 1'b1;
        bus_a.valid_i = 1'b0;
        bus_b.valid_i = 1'b0;
        bus_b.ready_i = 1'b1;
        #1;
        check("rel_a_valid", bus_a.valid_o, 0);
        check("rel_a_ready", bus_a.ready_o, 1);
        @(posedge clk);
        #1;

        // Streaming at full rate: each entry visible one cycle after acceptance
        for (int k = 1; k <= 10; k++) begin
            drive_a(1'b1, 1'b1, 1'b0, 2'(k), DW'(k));
            check("stream_valid", bus_a.valid_o, 1);
            check("stream_data",  bus_a.data_o, k);
            check("stream_ready", bus_a.ready_o, 1);
        end
        drive_a(1'b0, 1'b1, 1'b0, 2'b00, '0);
        check("stream_drained", bus_a.occ_o, 0);

        // Back-pressure, skid absorption, flush corner cases
        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i].valid, vecs[i].ready, vecs[i].flush, vecs[i].ctrl, DW'(vecs[i].data));
            check($sformatf("vec%0d_valid", i), bus_a.valid_o, vecs[i].exp_valid);
            check($sformatf("vec%0d_ready", i), bus_a.ready_o, vecs[i].exp_ready);
            check($sformatf("vec%0d_occ", i),   bus_a.occ_o,   vecs[i].exp_occ);
            check($sformatf("vec%0d_ctrl", i),  bus_a.ctrl_o,  vecs[i].exp_ctrl);
        end

        // Asynchronous reset while FULL: outputs clear between edges
        drive_a(1'b1, 1'b0, 1'b0, 2'b01, 69'h41);
        drive_a(1'b1, 1'b0, 1'b0, 2'b10, 69'h42);
        check("pre_async_occ", bus_a.occ_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", bus_a.valid_o, 0);
        check("async_occ",   bus_a.occ_o, 0);
        check("async_ready", bus_a.ready_o, 1);
        check("async_ctrl",  bus_a.ctrl_o, 0);
        bus_a.valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_a(1'b1, 1'b1, 1'b0, 2'b10, 69'h5A);
        check("post_async_data", bus_a.data_o, 69'h5A);
        drive_a(1'b0, 1'b1, 1'b0, 2'b00, '0);

        // Single-entry instance: continuous stream, downstream ready toggling
        for (int i = 0; i < 20; i++) begin
            drive_b(1'b1, (i % 2) == 1, 1'b0, 2'(i), DW'(32'h100 + $urandom_range(0, 255)));
        end
        drive_b(1'b1, 1'b0, 1'b0, 2'b11, 69'h66);
        drive_b(1'b1, 1'b0, 1'b1, 2'b01, 69'h67);
        check("b_flush_valid", bus_b.valid_o, 0);
        check("b_flush_ctrl",  bus_b.ctrl_o, 0);
        drive_b(1'b1, 1'b1, 1'b0, 2'b01, 69'h68);
        repeat (3) drive_b(1'b0, 1'b1, 1'b0, 2'b00, '0);

        check("a_queue_empty", exp_a.size(), 0);
        check("b_queue_empty", exp_b.size(), 0);
        check("b_pushed_min", b_pushed >= 10, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline register replacing the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the pipelined RISC-V core. It carries a generic control field and data payload with a valid/ready handshake, stall back-pressure, synchronous flush and an optional 2-entry skid buffer. With the skid buffer enabled, `ready_o` is a register output, which breaks the combinational stall path. Control bits are forced to zero whenever the output is a bubble, so a flushed or stalled stage can never cause a write.

## Interface
- `CTRL_W`, default 2: control field width (MEM/WB: RegWrite, MemToReg).
- `DATA_W`, default 69: data payload width (MEM/WB: ALU result 32 + read data 32 + rd 5).
- `SKID_EN`, default 1: 1 selects a 2-entry skid buffer with registered `ready_o`; 0 selects a single entry with combinational `ready_o`.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: synchronous flush; empties the stage at the next edge.
- `valid_i` input 1: upstream entry valid.
- `ready_o` output 1: stage can accept an entry this cycle.
- `ctrl_i` input CTRL_W: upstream control bits.
- `data_i` input DATA_W: upstream payload.
- `valid_o` output 1: head entry valid.
- `ready_i` input 1: downstream accepts the head entry (tie to 1 for WB).
- `ctrl_o` output CTRL_W: head control bits; all zero when `valid_o`=0.
- `data_o` output DATA_W: head payload; holds its last value when empty.
- `occ_o` output 2: occupancy, 0 to 2 (at most 1 when SKID_EN=0).

## Operation
**Handshake**
- Accept = `valid_i && ready_o`.
- Emit = `valid_o && ready_i`.
- Entries leave in strict FIFO order, each exactly once.

**State machine, SKID_EN=1** (states EMPTY, ONE, FULL)
- EMPTY: on accept, go to ONE.
- ONE with accept and emit together: stay in ONE; the head is replaced by the incoming entry.
- ONE with accept only: go to FULL; the incoming entry goes to the skid slot.
- ONE with emit only: go to EMPTY.
- FULL with emit: go to ONE; the skid entry moves to the head.
- `ready_o` = (state != FULL), driven from a register.
- While in FULL, an upstream `valid_i` is held off by `ready_o`=0.

**SKID_EN=0**
- Single entry.
- `ready_o` = !valid_o || ready_i (combinational).
- Accept and emit in the same cycle replace the entry.

**Flush**
- `flush_i`=1 at an edge sets state to EMPTY, `valid_o` to 0 and `occ_o` to 0.
- Flush takes priority over an accept in the same cycle; that entry is dropped, not stored.
- `ready_o` must not depend on `flush_i`.

**Bubble gating**
- `ctrl_o` = stored ctrl AND {CTRL_W{valid_o}}.
- `data_o` is not gated.

**Reset**
- `valid_o`=0, `ready_o`=1, `ctrl_o`=0, `data_o`=0, `occ_o`=0, state EMPTY.
- Asserting reset mid-transfer discards all entries immediately, without waiting for a clock edge.

## Timing
- Latency: an entry accepted at edge N appears on `valid_o`/`data_o` after edge N, 1 cycle.
- Throughput: 1 entry/cycle whenever `ready_i`=1.
- SKID_EN=1: `ready_o` falls one cycle after the stage fills. The skid slot absorbs the entry that arrives in that cycle.
- SKID_EN=1: `ready_o` rises the cycle after the first emit from FULL.
- `occ_o` updates at the same edge as the state.
- Simultaneous flush and emit: the downstream consumer takes the head in that cycle, then the stage is EMPTY.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum `pipe_state_t` {EMPTY, ONE, FULL};
  - per-stage width constants: `MEM_WB_CTRL_W`=2, `MEM_WB_DATA_W`=69, and the corresponding IF/ID, ID/EX and EX/MEM constants.
- Stage top levels instantiate `pipe_stage_reg` and pack/unpack their named fields. Field order is LSB first: rd, read data, ALU result.
- Single module, no sub-module.
- The SKID_EN branches are implemented with generate blocks.

## Test plan
- **Reset:** hold `rst_i`=0 with `valid_i`=1, then release. Required: `valid_o`=0, `ctrl_o`=0, `occ_o`=0, `ready_o`=1.
- **Streaming:** `ready_i`=1, send data 1..10 on consecutive cycles. Required: outputs 1..10 in order, each one cycle later, `ready_o` stays 1.
- **Back-pressure (SKID_EN=1):** `ready_i`=0 while sending 0xA and 0xB.
  - Required: `occ_o`=2 and `ready_o`=0 on the following cycle; 0xC is held off.
  - Raise `ready_i`. Required: output sequence 0xA, 0xB, 0xC with no loss or duplication.
- **Flush:** `flush_i` together with accept of ctrl=2'b11, data 0x55. Required: next cycle `valid_o`=0, `ctrl_o`=2'b00, `occ_o`=0.
- **Async reset mid-operation:** drop `rst_i` between edges while FULL. Required: `valid_o`=0 immediately, without waiting for an edge.
- **SKID_EN=0 pass-through:** `ready_i` toggling every cycle with a continuous input stream. Required: `ready_o`=!valid_o||ready_i each cycle, no entry lost.
